// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if
// Raster timing bundle between the VGA timing generator and its consumers
// (pattern generator, sync pin drivers).
//   i_CE          pixel clock enable, driven by the clocking logic
//   o_Col/o_Row   current column/row counters (CW bits, unsigned)
//   o_H_Sync      horizontal sync, at SYNC_POL level inside the sync region
//   o_V_Sync      vertical sync, at SYNC_POL level inside the sync region
//   o_Active      visible-area flag
//   o_Frame_Start one-enabled-cycle strobe at the (0,0) following a frame wrap
// master: the timing generator. slave: a consumer of the raster timing.
interface vga_timing_gen_if #(
  parameter int CW = 10
);
  logic          i_CE;
  logic [CW-1:0] o_Col;
  logic [CW-1:0] o_Row;
  logic          o_H_Sync;
  logic          o_V_Sync;
  logic          o_Active;
  logic          o_Frame_Start;

  modport master (
    input  i_CE,
    output o_Col, o_Row, o_H_Sync, o_V_Sync, o_Active, o_Frame_Start
  );

  modport slave (
    output i_CE,
    input  o_Col, o_Row, o_H_Sync, o_V_Sync, o_Active, o_Frame_Start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// VGA raster timing: column/row counters, porch-aware sync pulses, an
// active-video flag and a frame-start strobe. Defaults give 640x480 @ 60 Hz
// at a 25 MHz pixel rate, with the pixel rate set by a clock enable.
// Ports:
//   CLK  system clock
//   RST  synchronous reset, active-high (takes effect regardless of i_CE)
//   vga  timing bundle (master side), see vga_timing_gen_if
// Every flag is a registered decode of the next counter values, so flags and
// counters presented in the same cycle always describe the same pixel.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 18,
  parameter int H_SYNC   = 92,
  parameter int H_BP     = 50,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0,
  parameter int CW       = 10
) (
  input  logic            CLK,
  input  logic            RST,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int CWE     = CW + 1;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  // Region bounds carry one extra bit: an end bound may equal 2^CW when the
  // total exactly fills the counter range.
  localparam logic [CW:0] H_ACT_END  = CWE'(H_ACTIVE);
  localparam logic [CW:0] H_SYNC_BEG = CWE'(H_ACTIVE + H_FP);
  localparam logic [CW:0] H_SYNC_END = CWE'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0] V_ACT_END  = CWE'(V_ACTIVE);
  localparam logic [CW:0] V_SYNC_BEG = CWE'(V_ACTIVE + V_FP);
  localparam logic [CW:0] V_SYNC_END = CWE'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic SYNC_ON = (SYNC_POL != 0);

  // Half-open interval test [lo, hi); empty when lo == hi.
  function automatic logic in_span(input logic [CW-1:0] v,
                                   input logic [CW:0]   lo,
                                   input logic [CW:0]   hi);
    return ({1'b0, v} >= lo) && ({1'b0, v} < hi);
  endfunction

  function automatic logic sync_level(input logic in_sync);
    return in_sync ? SYNC_ON : ~SYNC_ON;
  endfunction

  logic [CW-1:0] col_p0;
  logic [CW-1:0] row_p0;
  logic          h_sync_p0;
  logic          v_sync_p0;
  logic          active_p0;
  logic          frame_start_p0;

  logic [CW-1:0] col_nxt;
  logic [CW-1:0] row_nxt;
  logic          line_adv;
  logic          frame_wrap;

  always_comb begin
    line_adv   = (col_p0 == H_LAST);
    frame_wrap = line_adv && (row_p0 == V_LAST);
    col_nxt    = line_adv ? '0 : col_p0 + 1'b1;
    row_nxt    = row_p0;
    if (line_adv) begin
      row_nxt = (row_p0 == V_LAST) ? '0 : row_p0 + 1'b1;
    end
  end

  // ---- stage p0: counters and flags decoded from the next counter values
  always_ff @(posedge CLK) begin
    if (RST) begin
      col_p0         <= '0;
      row_p0         <= '0;
      h_sync_p0      <= ~SYNC_ON;
      v_sync_p0      <= ~SYNC_ON;
      active_p0      <= 1'b1;
      frame_start_p0 <= 1'b0;
    end else if (vga.i_CE) begin
      col_p0         <= col_nxt;
      row_p0         <= row_nxt;
      h_sync_p0      <= sync_level(in_span(col_nxt, H_SYNC_BEG, H_SYNC_END));
      v_sync_p0      <= sync_level(in_span(row_nxt, V_SYNC_BEG, V_SYNC_END));
      active_p0      <= in_span(col_nxt, '0, H_ACT_END) &&
                        in_span(row_nxt, '0, V_ACT_END);
      frame_start_p0 <= frame_wrap;
    end
  end

  assign vga.o_Col         = col_p0;
  assign vga.o_Row         = row_p0;
  assign vga.o_H_Sync      = h_sync_p0;
  assign vga.o_V_Sync      = v_sync_p0;
  assign vga.o_Active      = active_p0;
  assign vga.o_Frame_Start = frame_start_p0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
// Bench for vga_timing_gen with a reduced raster so whole frames fit in a
// short run: H = 8 active + 2 FP + 3 sync + 2 BP = 15, V = 4 active + 1 FP +
// 2 sync + 0 BP = 7 (empty back porch, and H_TOTAL close to 2^CW with CW=4).
// Active-low sync. One frame = 105 enabled cycles.
module tb_vga_timing_gen;

  localparam int CW      = 4;
  localparam int H_TOTAL = 15;
  localparam int V_TOTAL = 7;

  typedef struct packed {
    logic [CW-1:0] col;
    logic [CW-1:0] row;
    logic          hs;
    logic          vs;
    logic          act;
    logic          fs;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  vga_timing_gen_if #(.CW(CW)) vga ();

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(0),
    .SYNC_POL(0), .CW(CW)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .vga(vga.master)
  );

  always #5 clk = ~clk;

  obs_t q[$];
  int   total  = 0;
  int   passed = 0;
  int   steps  = 0;

  // Reference raster position (what the DUT must present after the edge).
  int   mcol = 0;
  int   mrow = 0;
  logic mfs  = 1'b0;

  obs_t last_obs;

  function automatic obs_t expect_at(input int c, input int r, input logic fs);
    obs_t e;
    e.col = CW'(c);
    e.row = CW'(r);
    e.hs  = !(c >= 10 && c < 13);
    e.vs  = !(r >= 5 && r < 7);
    e.act = (c < 8) && (r < 4);
    e.fs  = fs;
    return e;
  endfunction

  task automatic chk_int(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step(input logic ce, input logic r);
    obs_t e, o;
    vga.i_CE = ce;
    rst      = r;
    if (r) begin
      mcol = 0; mrow = 0; mfs = 1'b0;
    end else if (ce) begin
      mfs = 1'b0;
      if (mcol == H_TOTAL - 1) begin
        mcol = 0;
        if (mrow == V_TOTAL - 1) begin
          mrow = 0;
          mfs  = 1'b1;
        end else begin
          mrow = mrow + 1;
        end
      end else begin
        mcol = mcol + 1;
      end
    end
    q.push_back(expect_at(mcol, mrow, mfs));
    @(posedge clk);
    #1;
    steps++;
    e = q.pop_front();
    o = {vga.o_Col, vga.o_Row, vga.o_H_Sync, vga.o_V_Sync,
         vga.o_Active, vga.o_Frame_Start};
    last_obs = o;
    total++;
    assert (o === e) passed++;
    else $error("FAIL step%0d ce=%0b rst=%0b: got col=%0d row=%0d hs=%0b vs=%0b act=%0b fs=%0b expected col=%0d row=%0d hs=%0b vs=%0b act=%0b fs=%0b",
                steps, ce, r, o.col, o.row, o.hs, o.vs, o.act, o.fs,
                e.col, e.row, e.hs, e.vs, e.act, e.fs);
  endtask

  initial begin
    int first_fs, second_fs, hs_low, fs_seen;
    vga.i_CE = 1'b0;

    // Reset with and without enable.
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);

    // Continuous enable for a little over two frames.
    first_fs = -1; second_fs = -1; hs_low = 0;
    for (int i = 1; i <= 230; i++) begin
      step(1'b1, 1'b0);
      if (i <= H_TOTAL && !last_obs.hs) hs_low++;
      if (last_obs.fs) begin
        if (first_fs < 0) first_fs = i;
        else if (second_fs < 0) second_fs = i;
      end
    end
    chk_int("hs_low_per_line", hs_low, 3);
    chk_int("first_frame_start", first_fs, 105);
    chk_int("frame_period", second_fs - first_fs, 105);

    // Alternating enable: outputs move only on enabled edges and the
    // frame-start strobe stays up through the following disabled cycle.
    fs_seen = 0;
    for (int i = 0; i < 240; i++) begin
      step(i[0] == 1'b0, 1'b0);
      if (last_obs.fs) fs_seen++;
    end
    chk_int("fs_cycles_alternating", fs_seen, 2);

    // Reset in mid-frame while disabled, then resume counting from zero.
    for (int i = 0; i < 300; i++) begin
      if (mrow == 2 && mcol == 12) break;
      step(1'b1, 1'b0);
    end
    chk_int("reached_row2_col12", int'(last_obs.row) * 16 + int'(last_obs.col), 2 * 16 + 12);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
    chk_int("resume_col", int'(last_obs.col), 5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates VGA raster timing: horizontal/vertical counters, porch-aware sync pulses, active-video flag and a frame-start strobe.
- Sits directly upstream of the pattern generator, which consumes o_Col/o_Row/o_Active to choose pixel colour.
- Drives VGA_HS/VGA_VS at the top level.
- Default parameters give 640x480 @ 60 Hz with a 25 MHz pixel rate, gated by a clock enable.

Parameters:
H_ACTIVE, 640, visible columns
H_FP, 18, horizontal front porch (pixels)
H_SYNC, 92, horizontal sync width (pixels)
H_BP, 50, horizontal back porch (pixels); H_TOTAL = sum of the four = 800
V_ACTIVE, 480, visible rows
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines); V_TOTAL = 525
SYNC_POL, 0, sync assertion level (0 = active-low pulses)
CW, 10, counter width; must satisfy 2^CW >= max(H_TOTAL, V_TOTAL)

Ports:
CLK  input  1  system clock
RST  input  1  synchronous reset, active-high
i_CE  input  1  pixel clock enable; all state advances only on CLK edges with i_CE=1
o_Col  output  CW  current column counter, 0..H_TOTAL-1
o_Row  output  CW  current row counter, 0..V_TOTAL-1
o_H_Sync  output  1  horizontal sync at SYNC_POL level during sync region
o_V_Sync  output  1  vertical sync at SYNC_POL level during sync region
o_Active  output  1  1 when o_Col<H_ACTIVE and o_Row<V_ACTIVE
o_Frame_Start  output  1  one-enabled-cycle strobe when counters wrap to (0,0)

Behaviour:
- Reset (RST=1 at CLK edge, regardless of i_CE):
  - o_Col=0, o_Row=0, o_Active=1
  - o_H_Sync=o_V_Sync=~SYNC_POL (deasserted)
  - o_Frame_Start=0
- Reset mid-frame aborts the frame immediately; no partial-line completion.
- i_CE=0: every output and register holds its value.
- Column counter, on each enabled edge:
  - o_Col = o_Col+1.
  - At o_Col=H_TOTAL-1 it wraps to 0 and the line-advance condition fires.
- Row counter:
  - Increments only on line-advance.
  - At o_Row=V_TOTAL-1 with line-advance, wraps to 0.
  - Simultaneous column and row wrap is the frame wrap.
- All flags are registered decodes of the NEXT counter values, so on every cycle they align with the o_Col/o_Row presented that cycle (zero skew, no extra latency stage).
- Horizontal regions:
  - active: col in [0, H_ACTIVE)
  - front porch: [H_ACTIVE, H_ACTIVE+H_FP)
  - sync: [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
  - back porch: remainder
- Vertical regions: identical construction using V_* parameters and row.
- o_H_Sync=SYNC_POL iff col in the horizontal sync region; depends on column only, so it pulses on every line including vertical blanking.
- o_V_Sync=SYNC_POL iff row in the vertical sync region; held for whole lines (column-independent).
- o_Active = horizontal active AND vertical active.
- o_Frame_Start:
  - 1 for exactly the enabled cycle in which counters present (0,0) following a frame wrap; 0 otherwise.
  - Not asserted by reset itself.
  - Holds its value while i_CE=0, so consumers qualify it with i_CE.
- Arithmetic: counters are unsigned CW bits; compares use unsigned CW-bit constants derived from parameters; no overflow, since wrap occurs before 2^CW.
- Degenerate parameters (any porch = 0) are legal; regions of zero width are simply never entered.

Test Plan:
- Reset then i_CE=1 continuous -> cycle 0: col=0,row=0,active=1,HS=VS=1,frame_start=0; after 639 more cycles col=639 active=1; next cycle col=640 active=0.
- Horizontal sync window -> HS=0 exactly for col 658..749 (92 cycles), HS=1 at col 657 and 750; H period 800 cycles every line.
- Vertical sync window -> VS=0 for rows 490..491 across all 800 columns of each; VS=1 at row 489 col 799 and row 492 col 0; active=0 for all rows >=480.
- Frame wrap at row=524,col=799 -> next enabled cycle col=0,row=0,frame_start=1, active=1; frame_start=0 the following cycle; period 420000 enabled cycles.
- i_CE toggling 1/0 alternately -> outputs change only on i_CE=1 edges; frame period 840000 CLK cycles; frame_start held across intervening i_CE=0 cycle.
- RST asserted at row=300,col=700 with i_CE=0 -> next edge col=0,row=0,HS=VS=1,active=1,frame_start=0; counting resumes from 0 when RST drops.
